// File: rtl/fib_demo_sequencer.sv
// Control sequencer for the lab 2 demo datapath: drives register-file enables,
// read selects, ALU opcode and immediate so the datapath fills r0..r15 with Fibonacci numbers.
module fib_demo_sequencer #(
    parameter int          DATA_W   = 16,
    parameter int          NUM_REGS = 16,
    parameter int          TICK_DIV = 50000000,
    parameter logic [3:0]  OP_ADD   = 4'b0101,
    parameter logic [3:0]  OP_MOV   = 4'b1101
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    output logic [NUM_REGS-1:0] regEnable,
    output logic [3:0]          ra_sel,
    output logic [3:0]          rb_sel,
    output logic [3:0]          alu_op,
    output logic [DATA_W-1:0]   imm,
    output logic                imm_sel,
    output logic [4:0]          step_count,
    output logic                done
);

    localparam int              CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT0,
        S_INIT1,
        S_COMP,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       k;
    logic [3:0]       dest;
    logic             step_state;
    logic             terminal;

    assign step_state = (state == S_INIT0) || (state == S_INIT1) || (state == S_COMP);
    assign terminal   = step_state && run && (cnt == CNT_MAX);

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            k          <= 4'd2;
            step_count <= 5'd0;
            done       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) state <= S_INIT0;
                end
                S_INIT0, S_INIT1, S_COMP: begin
                    if (run) begin
                        if (cnt == CNT_MAX) begin
                            cnt <= '0;
                            if (step_count != 5'd16) step_count <= step_count + 5'd1;
                            if (state == S_INIT0) begin
                                state <= S_INIT1;
                            end else if (state == S_INIT1) begin
                                state <= S_COMP;
                                k     <= 4'd2;
                            end else if (k == 4'd15) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                k <= k + 4'd1;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_DONE: ;
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    always_comb begin
        ra_sel  = 4'd0;
        rb_sel  = 4'd0;
        alu_op  = OP_ADD;
        imm     = '0;
        imm_sel = 1'b0;
        dest    = 4'd0;
        case (state)
            S_INIT0: begin
                imm_sel = 1'b1;
                alu_op  = OP_MOV;
                dest    = 4'd0;
            end
            S_INIT1: begin
                imm     = DATA_W'(1);
                imm_sel = 1'b1;
                alu_op  = OP_MOV;
                dest    = 4'd1;
            end
            S_COMP: begin
                ra_sel = k - 4'd1;
                rb_sel = k - 4'd2;
                dest   = k;
            end
            default: ;
        endcase
    end

    // A reset in a terminal-count cycle suppresses the write; the step is discarded anyway.
    assign regEnable = (terminal && !rst) ? (NUM_REGS'(1) << dest) : '0;

endmodule

// File: tb/tb_fib_demo_sequencer.sv
// Directed bench for fib_demo_sequencer: paced run with a datapath model, pause,
// mid-sequence reset, DONE hold, and back-to-back pulses at TICK_DIV=1.
module tb_fib_demo_sequencer;

    localparam logic [3:0] OP_ADD = 4'b0101;
    localparam logic [3:0] OP_MOV = 4'b1101;

    logic        clk = 1'b0;
    logic        rst_a, run_a, rst_b, run_b;
    logic [15:0] en_a, en_b, imm_a, imm_b;
    logic [3:0]  ra_a, rb_a, op_a, ra_b, rb_b, op_b;
    logic        isel_a, isel_b, done_a, done_b;
    logic [4:0]  sc_a, sc_b;
    logic [15:0] rf [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fib_demo_sequencer #(.DATA_W(16), .NUM_REGS(16), .TICK_DIV(4)) dut_a (
        .clk(clk), .rst(rst_a), .run(run_a), .regEnable(en_a), .ra_sel(ra_a), .rb_sel(rb_a),
        .alu_op(op_a), .imm(imm_a), .imm_sel(isel_a), .step_count(sc_a), .done(done_a)
    );

    fib_demo_sequencer #(.DATA_W(16), .NUM_REGS(16), .TICK_DIV(1)) dut_b (
        .clk(clk), .rst(rst_b), .run(run_b), .regEnable(en_b), .ra_sel(ra_b), .rb_sel(rb_b),
        .alu_op(op_b), .imm(imm_b), .imm_sel(isel_b), .step_count(sc_b), .done(done_b)
    );

    // Behavioural regfile + ALU standing in for the lab 2 datapath behind dut_a.
    always @(posedge clk) begin
        logic [15:0] b_op, res;
        b_op = isel_a ? imm_a : rf[rb_a];
        res  = (op_a == OP_MOV) ? b_op : rf[ra_a] + b_op;
        for (int i = 0; i < 16; i++)
            if (en_a[i]) rf[i] <= res;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 16'hdead;
        rst_a = 1'b1; run_a = 1'b0; rst_b = 1'b1; run_b = 1'b0;
        cyc(2);
        rst_a = 1'b0;
        cyc(1);

        check("rst_regEnable", en_a, 0);
        check("rst_alu_op", op_a, OP_ADD);
        check("rst_imm_sel", isel_a, 0);
        check("rst_step_count", sc_a, 0);
        check("rst_done", done_a, 0);
        cyc(3);
        check("idle_no_pulse", en_a, 0);

        run_a = 1'b1;
        #1;
        check("idle_run_no_pulse", en_a, 0);
        cyc(1);
        check("init0_alu_op", op_a, OP_MOV);
        check("init0_imm_sel", isel_a, 1);
        check("init0_imm", imm_a, 0);

        for (int s = 0; s < 16; s++) begin
            for (int c = 0; c < 4; c++) begin
                if (s == 1 && c == 0) begin
                    check("init1_imm", imm_a, 1);
                    check("init1_alu_op", op_a, OP_MOV);
                end
                if (s == 5 && c == 1) begin
                    check("k5_ra_sel", ra_a, 4);
                    check("k5_rb_sel", rb_a, 3);
                    check("k5_alu_op", op_a, OP_ADD);
                    run_a = 1'b0;
                    #1;
                    for (int p = 0; p < 10; p++) begin
                        check("pause_no_pulse", en_a, 0);
                        cyc(1);
                    end
                    check("pause_ra_held", ra_a, 4);
                    check("pause_rb_held", rb_a, 3);
                    check("pause_step_held", sc_a, 5);
                    run_a = 1'b1;
                    #1;
                end
                check($sformatf("pulse_s%0d_c%0d", s, c), en_a, (c == 3) ? (32'd1 << s) : 32'd0);
                cyc(1);
            end
            check($sformatf("step_count_s%0d", s), sc_a, s + 1);
        end

        check("done_flag", done_a, 1);
        check("done_regEnable", en_a, 0);
        check("done_step_count", sc_a, 16);
        check("done_alu_op", op_a, OP_ADD);
        check("r2", rf[2], 16'd1);
        check("r3", rf[3], 16'd2);
        check("r7", rf[7], 16'd13);
        check("r15", rf[15], 16'h0262);

        for (int t = 0; t < 6; t++) begin
            run_a = t[0];
            #1;
            check("done_toggle_regEnable", en_a, 0);
            cyc(1);
            check("done_toggle_done", done_a, 1);
            check("done_toggle_step", sc_a, 16);
        end

        // Restart and reset during COMP(k=9).
        rst_a = 1'b1; run_a = 1'b0;
        cyc(1);
        rst_a = 1'b0; run_a = 1'b1;
        cyc(1);
        cyc(36);
        check("k9_step_count", sc_a, 9);
        check("k9_ra_sel", ra_a, 8);
        cyc(2);
        rst_a = 1'b1;
        cyc(1);
        check("midrst_regEnable", en_a, 0);
        check("midrst_step_count", sc_a, 0);
        check("midrst_done", done_a, 0);
        check("midrst_ra_sel", ra_a, 0);
        rst_a = 1'b0;
        cyc(1);
        check("restart_init0_op", op_a, OP_MOV);
        cyc(3);
        check("restart_pulse_r0", en_a, 32'h0001);

        // Reset coinciding with a terminal count: no advance.
        rst_a = 1'b1;
        cyc(1);
        check("rst_tc_step_count", sc_a, 0);
        check("rst_tc_alu_op", op_a, OP_ADD);
        check("rst_tc_imm_sel", isel_a, 0);
        rst_a = 1'b0; run_a = 1'b0;

        // TICK_DIV=1: one pulse per cycle from INIT0 entry.
        rst_b = 1'b0;
        cyc(1);
        check("b_idle_no_pulse", en_b, 0);
        run_b = 1'b1;
        cyc(1);
        for (int s = 0; s < 16; s++) begin
            check($sformatf("b_pulse_%0d", s), en_b, 32'd1 << s);
            cyc(1);
        end
        check("b_done", done_b, 1);
        check("b_done_regEnable", en_b, 0);
        check("b_step_count", sc_b, 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
